// File: rtl/spu_cmd_sched.sv
// ============================================================================
// spu_cmd_sched : SPU front end - command FIFO, one-at-a-time engine dispatch,
//                 watchdog and gbuf port arbitration.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module spu_cmd_sched #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ENG    = 2,
    parameter int OP_W       = 2,
    parameter int CFG_W      = 96,
    parameter int CMD_DEPTH  = 4,
    parameter int TO_W       = 20
) (
    input  logic                          core_clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OP_W-1:0]               cmd_op,
    input  logic [CFG_W-1:0]              cmd_cfg,
    output logic [NUM_ENG-1:0]            eng_start,
    output logic [CFG_W-1:0]              eng_cfg,
    input  logic [NUM_ENG-1:0]            eng_end,
    input  logic [NUM_ENG-1:0]            eng_ren,
    input  logic [NUM_ENG-1:0]            eng_wen,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_raddr,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] eng_waddr,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] eng_wdata,
    output logic                          gbuf_cen,
    output logic                          gbuf_wen,
    output logic [ADDR_WIDTH-1:0]         gbuf_raddr,
    output logic [ADDR_WIDTH-1:0]         gbuf_waddr,
    output logic [DATA_WIDTH-1:0]         gbuf_din,
    output logic                          spu_end,
    output logic                          busy,
    output logic                          err_illegal,
    output logic                          err_timeout,
    input  logic                          err_clr,
    output logic [15:0]                   done_cnt
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    // Expiry is flagged on the (2**TO_W-1)-th RUN cycle, when the count reads 2**TO_W-2.
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state, w_next;
    logic [OP_W-1:0]       r_fifo_op  [CMD_DEPTH];
    logic [CFG_W-1:0]      r_fifo_cfg [CMD_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [NUM_ENG-1:0]    r_sel, r_start, w_dec;
    logic [CFG_W-1:0]      r_cfg;
    logic [TO_W-1:0]       r_wd;
    logic                  r_err_ill, r_err_to;
    logic [15:0]           r_done_cnt;
    logic                  w_full, w_empty, w_push, w_pop, w_legal, w_hit_end, w_expire;

    assign w_full    = (r_count == (PTR_W+1)'(CMD_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_LAUNCH);
    assign w_legal   = |w_dec;
    assign w_hit_end = |(eng_end & r_sel);
    assign w_expire  = (r_wd == WD_LAST);

    always_ff @(posedge core_clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]  <= cmd_op;
            r_fifo_cfg[r_wr_ptr] <= cmd_cfg;
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-hot engine select of the head command; all-zero means illegal op.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_dec[i] = (r_fifo_op[r_rd_ptr] == i[OP_W-1:0]);
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next = S_LAUNCH;
            S_LAUNCH: w_next = w_legal ? S_RUN : S_DONE;
            S_RUN:    if (w_hit_end || w_expire) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start    <= '0;
            r_sel      <= '0;
            r_cfg      <= '0;
            r_wd       <= '0;
            r_err_ill  <= 1'b0;
            r_err_to   <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            r_start <= '0;
            if (r_state == S_LAUNCH) begin
                r_cfg   <= r_fifo_cfg[r_rd_ptr];
                r_sel   <= w_dec;
                r_start <= w_dec;
                r_wd    <= '0;
            end
            if (r_state == S_RUN) r_wd <= r_wd + 1'b1;
            if (r_state == S_DONE) r_done_cnt <= r_done_cnt + 16'd1;
            if (err_clr) begin
                r_err_ill <= 1'b0;
                r_err_to  <= 1'b0;
            end else begin
                if (r_state == S_LAUNCH && !w_legal) r_err_ill <= 1'b1;
                if (r_state == S_RUN && w_expire && !w_hit_end) r_err_to <= 1'b1;
            end
        end
    end

    always_comb begin
        gbuf_cen   = 1'b1;
        gbuf_wen   = 1'b1;
        gbuf_raddr = '0;
        gbuf_waddr = '0;
        gbuf_din   = '0;
        if (r_state == S_RUN) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (r_sel[i]) begin
                    gbuf_cen   = ~(eng_ren[i] | eng_wen[i]);
                    gbuf_wen   = ~eng_wen[i];
                    gbuf_raddr = eng_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    gbuf_waddr = eng_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    gbuf_din   = eng_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign cmd_ready   = !w_full;
    assign eng_start   = r_start;
    assign eng_cfg     = r_cfg;
    assign spu_end     = (r_state == S_DONE);
    assign busy        = !w_empty || (r_state != S_IDLE);
    assign err_illegal = r_err_ill;
    assign err_timeout = r_err_to;
    assign done_cnt    = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spu_cmd_sched.sv
// ============================================================================
// tb_spu_cmd_sched : directed self-checking bench for spu_cmd_sched (TO_W=4).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_spu_cmd_sched;

    logic        core_clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [95:0] cmd_cfg;
    logic [1:0]  eng_start;
    logic [95:0] eng_cfg;
    logic [1:0]  eng_end;
    logic [1:0]  eng_ren;
    logic [1:0]  eng_wen;
    logic [23:0] eng_raddr;
    logic [23:0] eng_waddr;
    logic [63:0] eng_wdata;
    logic        gbuf_cen;
    logic        gbuf_wen;
    logic [11:0] gbuf_raddr;
    logic [11:0] gbuf_waddr;
    logic [31:0] gbuf_din;
    logic        spu_end;
    logic        busy;
    logic        err_illegal;
    logic        err_timeout;
    logic        err_clr;
    logic [15:0] done_cnt;

    int total = 0;
    int bad   = 0;

    spu_cmd_sched #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .NUM_ENG    (2),
        .OP_W       (2),
        .CFG_W      (96),
        .CMD_DEPTH  (4),
        .TO_W       (4)
    ) dut (
        .core_clk    (core_clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_cfg     (cmd_cfg),
        .eng_start   (eng_start),
        .eng_cfg     (eng_cfg),
        .eng_end     (eng_end),
        .eng_ren     (eng_ren),
        .eng_wen     (eng_wen),
        .eng_raddr   (eng_raddr),
        .eng_waddr   (eng_waddr),
        .eng_wdata   (eng_wdata),
        .gbuf_cen    (gbuf_cen),
        .gbuf_wen    (gbuf_wen),
        .gbuf_raddr  (gbuf_raddr),
        .gbuf_waddr  (gbuf_waddr),
        .gbuf_din    (gbuf_din),
        .spu_end     (spu_end),
        .busy        (busy),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .done_cnt    (done_cnt)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command and hold it until accepted (bounded).
    task automatic push(input logic [1:0] op, input logic [95:0] cfg);
        logic acc;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cfg   = cfg;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic wait_start(input logic [1:0] exp_start, input logic [95:0] exp_cfg, input string tag);
        for (int i = 0; i < 40; i++) begin
            if (eng_start != 2'b00) break;
            tick();
        end
        chk({tag, "_start"}, eng_start, exp_start);
        chk({tag, "_cfg"}, eng_cfg, exp_cfg);
    endtask

    task automatic finish_cmd(input logic [1:0] op, input string tag);
        eng_end = 2'b01 << op;
        tick();
        chk({tag, "_spu_end"}, spu_end, 1);
        eng_end = 2'b00;
    endtask

    initial begin
        logic [1:0]  ops  [4];
        logic [95:0] cfgs [4];
        logic        seen;
        ops  = '{2'd0, 2'd1, 2'd0, 2'd1};
        cfgs = '{96'h33, 96'h44, 96'h55, 96'h66};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_cfg = '0;
        eng_end = '0; eng_ren = '0; eng_wen = '0; eng_raddr = '0;
        eng_waddr = '0; eng_wdata = '0; err_clr = 1'b0;
        tick(); tick();

        // Reset values
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", eng_start, 0);
        chk("rst_cfg", eng_cfg, 0);
        chk("rst_gbuf", {gbuf_cen, gbuf_wen, gbuf_raddr, gbuf_waddr, gbuf_din}, {2'b11, 56'h0});
        chk("rst_status", {spu_end, err_illegal, err_timeout, done_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // Single command: start two cycles after the push edge
        push(2'd0, 96'hA5);
        chk("t1_busy", busy, 1);
        chk("t1_start_t0", eng_start, 0);
        tick();
        chk("t1_start_t1", eng_start, 0);
        tick();
        chk("t1_start_t2", eng_start, 2'b01);
        chk("t1_cfg", eng_cfg, 96'hA5);
        repeat (9) tick();
        chk("t1_no_end", spu_end, 0);
        finish_cmd(2'd0, "t1");
        tick();
        chk("t1_end_pulse", spu_end, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_idle", busy, 0);

        // FIFO fill while engine 0 is stalled on the first command
        push(2'd0, 96'h11);
        push(2'd1, 96'h22);
        push(2'd0, 96'h33);
        push(2'd1, 96'h44);
        push(2'd0, 96'h55);
        chk("t2_full", cmd_ready, 0);
        chk("t2_active_cfg", eng_cfg, 96'h11);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_cfg = 96'h66;
        repeat (3) tick();
        chk("t2_held", cmd_ready, 0);
        finish_cmd(2'd0, "t2_c1");
        tick();
        tick();
        chk("t2_ready_on_pop", cmd_ready, 0);
        tick();
        chk("t2_c2_start", eng_start, 2'b10);
        chk("t2_c2_cfg", eng_cfg, 96'h22);
        chk("t2_ready_after_pop", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("t2_full_again", cmd_ready, 0);
        tick();
        finish_cmd(2'd1, "t2_c2");
        for (int k = 0; k < 4; k++) begin
            wait_start(2'b01 << ops[k], cfgs[k], "t2_order");
            tick(); tick();
            finish_cmd(ops[k], "t2_order");
        end
        tick();
        chk("t2_done_cnt", done_cnt, 7);
        chk("t2_idle", busy, 0);

        // Illegal op
        push(2'd3, 96'h77);
        tick();
        chk("t3_launch_start", eng_start, 0);
        tick();
        chk("t3_spu_end", spu_end, 1);
        chk("t3_err", err_illegal, 1);
        chk("t3_no_start", eng_start, 0);
        tick();
        chk("t3_sticky", err_illegal, 1);
        chk("t3_done_cnt", done_cnt, 8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_clr", err_illegal, 0);

        // err_clr beats a same-cycle illegal-op set
        err_clr = 1'b1;
        push(2'd2, 96'h7E);
        tick();
        tick();
        chk("t3b_spu_end", spu_end, 1);
        chk("t3b_clr_prio", err_illegal, 0);
        err_clr = 1'b0;
        tick();
        chk("t3b_done_cnt", done_cnt, 9);

        // Watchdog expiry after 15 RUN cycles
        push(2'd0, 96'h88);
        wait_start(2'b01, 96'h88, "t4");
        repeat (14) tick();
        chk("t4_run15_end", spu_end, 0);
        chk("t4_run15_err", err_timeout, 0);
        tick();
        chk("t4_spu_end", spu_end, 1);
        chk("t4_err", err_timeout, 1);
        tick();

        // Next command runs normally; gbuf arbitration follows engine 1
        push(2'd1, 96'h99);
        wait_start(2'b10, 96'h99, "t5");
        eng_ren   = 2'b10;
        eng_raddr = {12'h123, 12'h000};
        eng_wen   = 2'b01;
        eng_waddr = {12'h000, 12'h0AB};
        eng_wdata = {32'h0, 32'hDEADBEEF};
        #1;
        chk("t5_rd_cen", gbuf_cen, 0);
        chk("t5_rd_wen", gbuf_wen, 1);
        chk("t5_raddr", gbuf_raddr, 12'h123);
        chk("t5_waddr_other", {gbuf_waddr, gbuf_din}, 0);
        eng_wen   = 2'b10;
        eng_waddr = {12'h456, 12'h0AB};
        eng_wdata = {32'hCAFEF00D, 32'hDEADBEEF};
        #1;
        chk("t5_wr_en", {gbuf_cen, gbuf_wen}, 2'b00);
        chk("t5_waddr", gbuf_waddr, 12'h456);
        chk("t5_din", gbuf_din, 32'hCAFEF00D);
        tick();
        eng_end = 2'b01;
        tick();
        eng_end = 2'b00;
        chk("t5_other_end_ignored", spu_end, 0);
        finish_cmd(2'd1, "t5");
        tick();
        chk("t5_idle_cen", {gbuf_cen, gbuf_raddr}, {1'b1, 12'h0});
        chk("t5_done_cnt", done_cnt, 11);
        chk("t5_to_sticky", err_timeout, 1);
        eng_ren = '0; eng_wen = '0; eng_raddr = '0; eng_waddr = '0; eng_wdata = '0;

        // Reset in the middle of RUN with one command queued
        push(2'd0, 96'hBB);
        wait_start(2'b01, 96'hBB, "t6");
        push(2'd1, 96'hCC);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        chk("t6_rst_cfg", eng_cfg, 0);
        chk("t6_rst_status", {spu_end, err_illegal, err_timeout, done_cnt}, 0);
        tick(); tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen = seen | spu_end | (|eng_start) | busy;
        end
        chk("t6_quiet_after_rst", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
